// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/fetch_unit.sv
// Phase-driven instruction fetch: fetches at pc, latches ir, raises hlt on HALT_OP.
// Optional macro IFETCH_TIMEOUT_EN: a fetch still unanswered in R faults the core.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   phase,
    fetch_unit_if.master imem,
    input  logic         br_taken,
    input  logic [31:0]  br_target,
    output logic [31:0]  pc,
    output logic [31:0]  ir,
    output logic         hlt,
    output logic         fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HAVE = 2'd2,
        FLT  = 2'd3
    } state_e;

    function automatic logic is_one_hot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        hlt_q, hlt_d;
    logic        fault_q, fault_d;

    logic        phase_ok_s;
    logic        ph_f_s, ph_r_s, ph_x_s, ph_w_s;
    logic        req_s;
    logic        ack_s;

    // Phase decode; anything that is not exactly one bit set is treated as a no-op phase.
    always_comb begin
        phase_ok_s = is_one_hot(phase);
        ph_f_s     = (phase == 5'b00001);
        ph_r_s     = (phase == 5'b00010);
        ph_x_s     = (phase == 5'b00100);
        ph_w_s     = (phase == 5'b10000);
    end

    // Memory request is combinational so a same-cycle ack in F can complete the fetch.
    always_comb begin
        req_s = 1'b0;
        if (rst) begin
            req_s = 1'b0;
        end else if ((state_q == IDLE) && ph_f_s) begin
            req_s = 1'b1;
        end else if ((state_q == REQ) && phase_ok_s) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        ack_s = req_s & imem.imem_ack;
    end

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_q;

    // Next-state, instruction capture and halt/fault detection.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        hlt_d   = hlt_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (ph_f_s) begin
                    if (ack_s) begin
                        state_d = HAVE;
                        ir_d    = imem.imem_rdata;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = HAVE;
                    ir_d    = imem.imem_rdata;
`ifdef IFETCH_TIMEOUT_EN
                end else if (ph_r_s) begin
                    state_d = FLT;
                    fault_d = 1'b1;
                    hlt_d   = 1'b1;
`else
                end else if (ph_r_s) begin
                    // Without the timeout the request simply stays open for a later ack.
                    state_d = REQ;
`endif
                end else begin
                    state_d = REQ;
                end
            end
            HAVE: begin
                if (ph_w_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HAVE;
                end
                if (ph_x_s && (ir_q[31:26] == HALT_OP)) begin
                    hlt_d = 1'b1;
                end else begin
                    hlt_d = hlt_q;
                end
            end
            FLT: begin
                state_d = FLT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // pc advances only in W and freezes once the core is halted or faulted.
    always_comb begin
        pc_d = pc_q;
        if (ph_w_s && !hlt_q && !fault_q) begin
            if (br_taken) begin
                pc_d = br_target;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers with synchronous reset; reset drops any outstanding fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
            hlt_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            hlt_q   <= hlt_d;
            fault_q <= fault_d;
        end
    end

    assign pc    = pc_q;
    assign ir    = ir_q;
    assign hlt   = hlt_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a queue-based scoreboard and negedge monitor.
module tb_fetch_unit;

    localparam logic [4:0] P0 = 5'b00000;
    localparam logic [4:0] PF = 5'b00001;
    localparam logic [4:0] PR = 5'b00010;
    localparam logic [4:0] PX = 5'b00100;
    localparam logic [4:0] PM = 5'b01000;
    localparam logic [4:0] PW = 5'b10000;

    logic        clk;
    logic        rst;
    logic [4:0]  phase;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        hlt;
    logic        fault;

    fetch_unit_if imem_if ();

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .imem      (imem_if),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc        (pc),
        .ir        (ir),
        .hlt       (hlt),
        .fault     (fault)
    );

    typedef struct {
        int          due;
        string       nm;
        logic        xr;
        logic [31:0] xpc;
        logic [31:0] xir;
        logic        xh;
        logic        xf;
    } exp_t;

    exp_t q[$];
    int   cycle;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
        end
    endtask

    // Monitor: pop the expectation due this cycle and compare every observable output.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cycle) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "req",   {31'd0, imem_if.imem_req}, {31'd0, e.xr});
            cmp(e.nm, "addr",  imem_if.imem_addr, e.xpc);
            cmp(e.nm, "pc",    pc, e.xpc);
            cmp(e.nm, "ir",    ir, e.xir);
            cmp(e.nm, "hlt",   {31'd0, hlt}, {31'd0, e.xh});
            cmp(e.nm, "fault", {31'd0, fault}, {31'd0, e.xf});
        end
    end

    // One cycle of stimulus; expectations describe outputs seen during this cycle.
    task automatic step(input string nm, input logic chk, input logic r, input logic [4:0] ph,
                        input logic ak, input logic [31:0] rd, input logic bt, input logic [31:0] tg,
                        input logic xr, input logic [31:0] xpc, input logic [31:0] xir,
                        input logic xh, input logic xf);
        exp_t e;
        rst                = r;
        phase              = ph;
        imem_if.imem_ack   = ak;
        imem_if.imem_rdata = rd;
        br_taken           = bt;
        br_target          = tg;
        if (chk) begin
            e.due = cycle; e.nm = nm; e.xr = xr; e.xpc = xpc; e.xir = xir; e.xh = xh; e.xf = xf;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cycle = 0; checks = 0; errors = 0;
        rst = 1'b1; phase = P0; br_taken = 1'b0; br_target = 32'h0;
        imem_if.imem_ack = 1'b0; imem_if.imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        // reset state, request suppressed while rst is high even in F
        step("rst_state", 1, 1, PF, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        // fetch acked in F, sequential W
        step("a_f",  1, 0, PF, 1, 32'h1234_5678, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        step("a_r",  1, 0, PR, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1234_5678, 0, 0);
        step("a_x",  1, 0, PX, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1234_5678, 0, 0);
        step("a_m",  1, 0, PM, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1234_5678, 0, 0);
        step("a_w",  1, 0, PW, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1234_5678, 0, 0);
        // fetch acked in R, taken branch
        step("b_f",  1, 0, PF, 0, 32'h0, 0, 32'h0, 1, 32'h4, 32'h1234_5678, 0, 0);
        step("b_r",  1, 0, PR, 1, 32'hA000_0001, 0, 32'h0, 1, 32'h4, 32'h1234_5678, 0, 0);
        step("b_x",  1, 0, PX, 0, 32'h0, 0, 32'h0, 0, 32'h4, 32'hA000_0001, 0, 0);
        step("b_m",  1, 0, PM, 0, 32'h0, 0, 32'h0, 0, 32'h4, 32'hA000_0001, 0, 0);
        step("b_w",  1, 0, PW, 0, 32'h0, 1, 32'h0000_0100, 0, 32'h4, 32'hA000_0001, 0, 0);
        // stray acks while idle and with illegal phase vectors
        step("c_idle",  1, 0, P0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 32'h100, 32'hA000_0001, 0, 0);
        step("c_multi", 1, 0, 5'b10001, 1, 32'hDEAD_BEEF, 1, 32'h0000_0BAD, 0, 32'h100, 32'hA000_0001, 0, 0);
        step("c_after", 1, 0, P0, 0, 32'h0, 0, 32'h0, 0, 32'h100, 32'hA000_0001, 0, 0);
        // branch to top of address space, then wrap
        step("d_f1", 1, 0, PF, 1, 32'h0000_0000, 0, 32'h0, 1, 32'h100, 32'hA000_0001, 0, 0);
        step("d_r1", 1, 0, PR, 0, 32'h0, 0, 32'h0, 0, 32'h100, 32'h0, 0, 0);
        step("d_x1", 1, 0, PX, 0, 32'h0, 0, 32'h0, 0, 32'h100, 32'h0, 0, 0);
        step("d_m1", 1, 0, PM, 0, 32'h0, 0, 32'h0, 0, 32'h100, 32'h0, 0, 0);
        step("d_w1", 1, 0, PW, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h100, 32'h0, 0, 0);
        step("d_f2", 1, 0, PF, 1, 32'h1111_1111, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0);
        step("d_r2", 1, 0, PR, 0, 32'h0, 0, 32'h0, 0, 32'hFFFF_FFFC, 32'h1111_1111, 0, 0);
        step("d_x2", 1, 0, PX, 0, 32'h0, 0, 32'h0, 0, 32'hFFFF_FFFC, 32'h1111_1111, 0, 0);
        step("d_m2", 1, 0, PM, 0, 32'h0, 0, 32'h0, 0, 32'hFFFF_FFFC, 32'h1111_1111, 0, 0);
        step("d_w2", 1, 0, PW, 0, 32'h0, 0, 32'h0, 0, 32'hFFFF_FFFC, 32'h1111_1111, 0, 0);
        // no ack through F and R
        step("e_f",  1, 0, PF, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h1111_1111, 0, 0);
        step("e_r",  1, 0, PR, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h1111_1111, 0, 0);
`ifdef IFETCH_TIMEOUT_EN
        step("e_x",  1, 0, PX, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1111_1111, 1, 1);
        step("e_m",  1, 0, PM, 1, 32'h3333_3333, 0, 32'h0, 0, 32'h0, 32'h1111_1111, 1, 1);
        step("e_w",  1, 0, PW, 0, 32'h0, 1, 32'h0000_0080, 0, 32'h0, 32'h1111_1111, 1, 1);
        step("e_f2", 1, 0, PF, 1, 32'h3333_3333, 0, 32'h0, 0, 32'h0, 32'h1111_1111, 1, 1);
        step("e_end", 1, 0, P0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1111_1111, 1, 1);
`else
        step("e_x",  1, 0, PX, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h1111_1111, 0, 0);
        step("e_m",  1, 0, PM, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h1111_1111, 0, 0);
        step("e_w",  1, 0, PW, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h1111_1111, 0, 0);
        step("e_f2", 1, 0, PF, 1, 32'h2222_2222, 0, 32'h0, 1, 32'h4, 32'h1111_1111, 0, 0);
        step("e_end", 1, 0, PR, 0, 32'h0, 0, 32'h0, 0, 32'h4, 32'h2222_2222, 0, 0);
`endif
        // reset during an open request, late ack afterwards
        step("g_rst0", 0, 1, P0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        step("g_rst",  1, 1, P0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        step("g_f",    1, 0, PF, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        step("g_mid",  1, 1, PR, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        step("g_late", 1, 0, PR, 1, 32'h5555_5555, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        step("g_chk",  1, 0, P0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        // halt opcode
        step("h_f",  1, 0, PF, 1, 32'hFC00_0000, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        step("h_r",  1, 0, PR, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'hFC00_0000, 0, 0);
        step("h_x",  1, 0, PX, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'hFC00_0000, 0, 0);
        step("h_m",  1, 0, PM, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'hFC00_0000, 1, 0);
        step("h_w",  1, 0, PW, 0, 32'h0, 1, 32'h0000_0040, 0, 32'h0, 32'hFC00_0000, 1, 0);
        step("h_0a", 1, 0, P0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'hFC00_0000, 1, 0);
        step("h_0b", 1, 0, P0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'hFC00_0000, 1, 0);
        // reset clears the sticky halt
        step("i_rst", 0, 1, P0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        step("i_chk", 1, 0, P0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-002 Parameter HALT_OP, default 6'h3F: opcode in ir[31:26] that halts the core.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 phase  in  5  one-hot phase vector from the phase generator: bit0=F (fetch), bit1=R, bit2=X, bit3=M, bit4=W; all-zero means idle.
REQ-006 imem_req  out  1  instruction memory read request, combinational.
REQ-007 imem_addr  out  32  read address, always equal to pc.
REQ-008 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-009 imem_ack  in  1  read completion, sampled at posedge while imem_req=1.
REQ-010 br_taken  in  1  branch decision, sampled only in W.
REQ-011 br_target  in  32  branch destination, sampled only in W.
REQ-012 pc  out  32  current instruction address, registered.
REQ-013 ir  out  32  instruction register, registered.
REQ-014 hlt  out  1  halt request to the phase generator, registered, sticky.
REQ-015 fault  out  1  fetch-timeout flag, registered, sticky.

Function
REQ-016 The fetch FSM SHALL have exactly four states: IDLE, REQ, HAVE, FLT.
REQ-017 IDLE->REQ on a cycle with phase==5'b00001 and no ack; IDLE->HAVE on that cycle if imem_ack=1.
REQ-018 REQ->HAVE on imem_ack=1 when phase[1]=1; REQ->FLT on phase[1]=1 with imem_ack=0.
REQ-019 HAVE->IDLE on phase[4]=1; FLT is terminal until reset.
REQ-020 imem_req SHALL be 1 iff (state==IDLE and phase==5'b00001) or state==REQ, and 0 while rst=1.
REQ-021 On an accepted ack, ir SHALL load imem_rdata at that edge: ack in F -> new ir visible in R; ack in R -> new ir visible in X.
REQ-022 imem_ack while imem_req=0 SHALL be ignored (no ir change).
REQ-023 On phase[2]=1 with ir[31:26]==HALT_OP and state==HAVE, hlt SHALL be set at that edge.
REQ-024 On phase[4]=1 with hlt=0, pc SHALL load br_target if br_taken=1, else pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-025 pc SHALL NOT change in any phase other than W, nor once hlt or fault is 1.
REQ-026 Entering FLT SHALL set fault=1 and hlt=1 at the same edge.
REQ-027 Any phase value not one-hot (including multiple bits set) SHALL cause no state, pc, or ir change and imem_req=0.
REQ-028 hlt and fault, once set, SHALL remain set until rst.

Reset
REQ-029 While rst=1 at posedge: state=IDLE, pc=RESET_PC, ir=0, hlt=0, fault=0; imem_req=0 combinationally.
REQ-030 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_ack after reset SHALL be ignored.

Configuration
REQ-031 Macro IFETCH_TIMEOUT_EN: when defined, REQ-018/REQ-026 apply as written.
REQ-032 When IFETCH_TIMEOUT_EN is undefined, REQ->FLT SHALL NOT exist; REQ stays in REQ across phases, accepting the next ack, and fault is tied 0; HAVE->IDLE still on phase[4].

Verification
REQ-033 Reset, then F with ack and rdata=32'h1234_5678 -> ir=32'h1234_5678 in R; W with br_taken=0 -> pc=32'h4.
REQ-034 F without ack, ack in R with rdata=32'hA000_0001 -> ir updated in X, fault=0; W with br_taken=1, br_target=32'h0000_0100 -> pc=32'h100.
REQ-035 Fetch returns 32'hFC00_0000 (opcode 6'h3F) -> hlt=1 from M onward; pc unchanged after phase vector goes 0.
REQ-036 IFETCH_TIMEOUT_EN defined, no ack through F and R -> fault=1 and hlt=1 in X; stuck until rst; without macro, same stimulus -> fault=0, ack in next F accepted.
REQ-037 pc=32'hFFFF_FFFC, W with br_taken=0 -> pc=32'h0; stray ack while idle -> ir unchanged.
REQ-038 rst asserted during REQ, ack arrives next cycle -> state IDLE, ir=0, pc=RESET_PC.
